pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//  Producer side of the PC-select interface: resolves jumps/branches in ID and drives
//  JRJZ plus the three target addresses into the instruction-pointer mux. Holds a redirect
//  stable across IF stalls, squashes the wrong-path IF instruction, counts redirects.
//  Sits between the ID-stage decoder/register file and the PC-select mux.
// PARAMETERS
//  FLUSH_EN  1   1: assert flush_if while a redirect is pending; 0: branch-delay-slot mode, flush_if tied 0
//  CNT_W     16  width of redirect_cnt
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  stall        in   1   IF/PC hold from hazard unit; PC mux output not consumed while 1
//  id_valid     in   1   ID-stage instruction valid
//  id_is_beq    in   1   decoded BEQ
//  id_is_bne    in   1   decoded BNE
//  id_is_j      in   1   decoded J/JAL
//  id_is_jr     in   1   decoded JR
//  id_pc_plus4  in   32  PC+4 of ID instruction
//  id_imm16     in   16  branch offset (word units)
//  id_index26   in   26  jump instr_index
//  id_rs_data   in   32  rs operand (forwarded)
//  id_rt_data   in   32  rt operand (forwarded)
//  JRJZ         out  3   000 NextPC, 001 Branch, 010 Jump, 100 Jr; no other code ever driven
//  BranchAddr   out  32  registered branch target
//  JumpAddr     out  32  registered jump target
//  JrAddr       out  32  registered register target
//  flush_if     out  1   squash IF/ID register contents
//  redirect_cnt out  CNT_W  redirects consumed, saturating
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, JRJZ=000, all addresses 0, flush_if=0, redirect_cnt=0.
//  All outputs registered; JRJZ valid one cycle after ID acceptance.
//  Accept: in IDLE, at edge with id_valid=1 & stall=0. Decode ignored in any other case.
//  Target math (mod 2^32, carry dropped):
//   BranchAddr = id_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}
//   JumpAddr   = {id_pc_plus4[31:28], id_index26, 2'b00}
//   JrAddr     = id_rs_data
//  Taken: beq & rs==rt; bne & rs!=rt; j; jr. Priority if several set: jr > j > beq/bne.
//  FSM:
//   IDLE: JRJZ=000. Accepted & taken -> REDIRECT, load code + only the selected address
//         (others keep value). Not taken or no control instr -> stay IDLE.
//   REDIRECT: JRJZ holds code, address held; flush_if=FLUSH_EN. stall=1 -> stay (held
//         unchanged, any length). stall=0 -> edge consumes: ++redirect_cnt (sat at all-ones),
//         JRJZ<=000, flush_if<=0, -> IDLE.
//  Back-to-back: ID instruction present during REDIRECT is wrong-path, never accepted.
//  Next acceptance earliest one cycle after return to IDLE.
//  Unused 3'b011/101/110/111 unreachable; a stray state returns to IDLE with JRJZ=000.
// STRUCTURE
//  Shared pkg: JRJZ_NEXT=3'b000, JRJZ_BR=3'b001, JRJZ_J=3'b010, JRJZ_JR=3'b100; state encodings.
//  One sub-module: pc_target_calc (combinational, three targets + taken/code select).
//  Top: FSM, output regs, saturating counter.
// TESTING
//  1 BEQ pc+4=0x00400010, imm=0x0003, rs=rt=5 -> next cycle JRJZ=001, BranchAddr=0x0040001C, flush_if=1; then IDLE, cnt=1
//  2 BNE rs=rt=7 -> JRJZ stays 000, flush_if 0, cnt unchanged; imm=0xFFFF pc+4=0x0 taken -> BranchAddr=0xFFFFFFFC
//  3 J pc+4=0xA0000004, index=0x0000100 -> JRJZ=010, JumpAddr=0xA0000400; JR rs=0x1234 -> JRJZ=100, JrAddr=0x00001234
//  4 JR accepted, stall=1 for 3 cycles -> JRJZ=100 and JrAddr held 3 cycles, cnt increments once after stall drops
//  5 is_jr & is_j & is_beq all set -> JRJZ=100; new id_valid during REDIRECT ignored; FLUSH_EN=0 -> flush_if always 0
//  6 reset asserted mid-REDIRECT (async, between edges) -> JRJZ=000, addrs 0, cnt 0 immediately; CNT_W=2 saturates at 3

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// Shared PC-select codes and redirect FSM state encoding for the PC redirect unit.
package pc_redirect_unit_pkg;

    localparam logic [2:0] JRJZ_NEXT = 3'b000;
    localparam logic [2:0] JRJZ_BR   = 3'b001;
    localparam logic [2:0] JRJZ_J    = 3'b010;
    localparam logic [2:0] JRJZ_JR   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01
    } redirectState_t;

    // Branch offset is in words: sign-extend and scale to bytes.
    function automatic logic [31:0] wordOffset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// ID-stage decode inputs and PC-select outputs of the redirect unit.
interface pc_redirect_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic             id_valid;
    logic             id_is_beq;
    logic             id_is_bne;
    logic             id_is_j;
    logic             id_is_jr;
    logic [31:0]      id_pc_plus4;
    logic [15:0]      id_imm16;
    logic [25:0]      id_index26;
    logic [31:0]      id_rs_data;
    logic [31:0]      id_rt_data;
    logic [2:0]       JRJZ;
    logic [31:0]      BranchAddr;
    logic [31:0]      JumpAddr;
    logic [31:0]      JrAddr;
    logic             flush_if;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        input  stall, id_valid, id_is_beq, id_is_bne, id_is_j, id_is_jr,
               id_pc_plus4, id_imm16, id_index26, id_rs_data, id_rt_data,
        output JRJZ, BranchAddr, JumpAddr, JrAddr, flush_if, redirect_cnt
    );

    modport slave (
        output stall, id_valid, id_is_beq, id_is_bne, id_is_j, id_is_jr,
               id_pc_plus4, id_imm16, id_index26, id_rs_data, id_rt_data,
        input  JRJZ, BranchAddr, JumpAddr, JrAddr, flush_if, redirect_cnt
    );
endinterface

// File: rtl/pc_redirect_unit_pc_target_calc.sv
// Combinational target computation and taken/select resolution for ID-stage control flow.
module pc_target_calc
    import pc_redirect_unit_pkg::*;
(
    input  logic        isBeq,
    input  logic        isBne,
    input  logic        isJ,
    input  logic        isJr,
    input  logic [31:0] pcPlus4,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] rsData,
    input  logic [31:0] rtData,
    output logic [31:0] branchAddr,
    output logic [31:0] jumpAddr,
    output logic [31:0] jrAddr,
    output logic        taken,
    output logic [2:0]  code
);
    logic operandsEqual;

    assign operandsEqual = (rsData == rtData);
    assign branchAddr    = pcPlus4 + wordOffset(imm16);
    assign jumpAddr      = {pcPlus4[31:28], index26, 2'b00};
    assign jrAddr        = rsData;

    // Register jumps win over direct jumps, which win over conditional branches.
    always_comb begin
        taken = 1'b0;
        code  = JRJZ_NEXT;
        if (isJr) begin
            taken = 1'b1;
            code  = JRJZ_JR;
        end else if (isJ) begin
            taken = 1'b1;
            code  = JRJZ_J;
        end else if ((isBeq && operandsEqual) || (isBne && !operandsEqual)) begin
            taken = 1'b1;
            code  = JRJZ_BR;
        end
    end
endmodule

// File: rtl/pc_redirect_unit.sv
// Resolves ID-stage jumps/branches and holds the selected PC redirect until the IF stage consumes it.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter bit          FLUSH_EN = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    pc_redirect_unit_if.master bus
);
    redirectState_t   state;
    logic [2:0]       jrjzQ;
    logic [31:0]      branchAddrQ;
    logic [31:0]      jumpAddrQ;
    logic [31:0]      jrAddrQ;
    logic             flushQ;
    logic [CNT_W-1:0] cntQ;

    logic [31:0] branchAddr;
    logic [31:0] jumpAddr;
    logic [31:0] jrAddr;
    logic        taken;
    logic [2:0]  code;

    pc_target_calc targetCalc (
        .isBeq      (bus.id_is_beq),
        .isBne      (bus.id_is_bne),
        .isJ        (bus.id_is_j),
        .isJr       (bus.id_is_jr),
        .pcPlus4    (bus.id_pc_plus4),
        .imm16      (bus.id_imm16),
        .index26    (bus.id_index26),
        .rsData     (bus.id_rs_data),
        .rtData     (bus.id_rt_data),
        .branchAddr (branchAddr),
        .jumpAddr   (jumpAddr),
        .jrAddr     (jrAddr),
        .taken      (taken),
        .code       (code)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            jrjzQ       <= JRJZ_NEXT;
            branchAddrQ <= '0;
            jumpAddrQ   <= '0;
            jrAddrQ     <= '0;
            flushQ      <= 1'b0;
            cntQ        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    jrjzQ  <= JRJZ_NEXT;
                    flushQ <= 1'b0;
                    if (bus.id_valid && !bus.stall && taken) begin
                        state  <= ST_REDIRECT;
                        jrjzQ  <= code;
                        flushQ <= FLUSH_EN;
                        // Only the chosen target is captured; the other two keep their last value.
                        case (code)
                            JRJZ_JR: jrAddrQ     <= jrAddr;
                            JRJZ_J:  jumpAddrQ   <= jumpAddr;
                            default: branchAddrQ <= branchAddr;
                        endcase
                    end
                end
                ST_REDIRECT: begin
                    if (!bus.stall) begin
                        state  <= ST_IDLE;
                        jrjzQ  <= JRJZ_NEXT;
                        flushQ <= 1'b0;
                        if (cntQ != '1) begin
                            cntQ <= cntQ + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    jrjzQ  <= JRJZ_NEXT;
                    flushQ <= 1'b0;
                end
            endcase
        end
    end

    assign bus.JRJZ         = jrjzQ;
    assign bus.BranchAddr   = branchAddrQ;
    assign bus.JumpAddr     = jumpAddrQ;
    assign bus.JrAddr       = jrAddrQ;
    assign bus.flush_if     = flushQ;
    assign bus.redirect_cnt = cntQ;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench: two instances (flush/16-bit counter, delay-slot/2-bit counter) share one stimulus stream.
module tb_pc_redirect_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall, idValid, isBeq, isBne, isJ, isJr;
    logic [31:0] pcP4, rs, rt;
    logic [15:0] imm;
    logic [25:0] idx;

    int nChecks = 0;
    int nFail   = 0;

    // Reference state: one pending redirect or none.
    bit          mPend;
    logic [2:0]  mCode;
    logic [31:0] mBr, mJ, mJr;
    int          mCntA, mCntB;

    pc_redirect_unit_if #(.CNT_W(16)) ifA ();
    pc_redirect_unit_if #(.CNT_W(2))  ifB ();

    assign ifA.stall = stall;        assign ifB.stall = stall;
    assign ifA.id_valid = idValid;   assign ifB.id_valid = idValid;
    assign ifA.id_is_beq = isBeq;    assign ifB.id_is_beq = isBeq;
    assign ifA.id_is_bne = isBne;    assign ifB.id_is_bne = isBne;
    assign ifA.id_is_j = isJ;        assign ifB.id_is_j = isJ;
    assign ifA.id_is_jr = isJr;      assign ifB.id_is_jr = isJr;
    assign ifA.id_pc_plus4 = pcP4;   assign ifB.id_pc_plus4 = pcP4;
    assign ifA.id_imm16 = imm;       assign ifB.id_imm16 = imm;
    assign ifA.id_index26 = idx;     assign ifB.id_index26 = idx;
    assign ifA.id_rs_data = rs;      assign ifB.id_rs_data = rs;
    assign ifA.id_rt_data = rt;      assign ifB.id_rt_data = rt;

    pc_redirect_unit #(.FLUSH_EN(1'b1), .CNT_W(16)) dutA (.clk(clk), .reset(reset), .bus(ifA));
    pc_redirect_unit #(.FLUSH_EN(1'b0), .CNT_W(2))  dutB (.clk(clk), .reset(reset), .bus(ifB));

    always #5 clk = ~clk;

    function automatic void modelReset();
        mPend = 1'b0; mCode = 3'b000; mBr = '0; mJ = '0; mJr = '0; mCntA = 0; mCntB = 0;
    endfunction

    // Applies the behavioural rules for one rising edge using the currently driven inputs.
    function automatic void modelEdge();
        if (mPend) begin
            if (!stall) begin
                mPend = 1'b0;
                mCode = 3'b000;
                if (mCntA < 65535) mCntA = mCntA + 1;
                if (mCntB < 3) mCntB = mCntB + 1;
            end
        end else begin
            mCode = 3'b000;
            if (idValid && !stall) begin
                if (isJr) begin
                    mPend = 1'b1; mCode = 3'b100; mJr = rs;
                end else if (isJ) begin
                    mPend = 1'b1; mCode = 3'b010;
                    mJ = (pcP4 & 32'hF000_0000) | (32'(idx) * 4);
                end else if ((isBeq && rs == rt) || (isBne && rs != rt)) begin
                    mPend = 1'b1; mCode = 3'b001;
                    mBr = pcP4 + 32'(int'($signed(imm)) * 4);
                end
            end
        end
    endfunction

    task automatic cycle();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic setInstr(input logic v, input logic beq, input logic bne, input logic j, input logic jr,
                            input logic [31:0] p, input logic [15:0] im, input logic [25:0] ix,
                            input logic [31:0] a, input logic [31:0] b);
        idValid = v; isBeq = beq; isBne = bne; isJ = j; isJr = jr;
        pcP4 = p; imm = im; idx = ix; rs = a; rt = b;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0;
        setInstr(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        nChecks++; if (ifA.JRJZ !== 3'b000) begin nFail++; $display("FAIL reset_JRJZ: got %b want 000", ifA.JRJZ); end
        nChecks++; if ({ifA.BranchAddr, ifA.JumpAddr, ifA.JrAddr} !== 96'h0) begin nFail++; $display("FAIL reset_addrs: got %h %h %h want 0", ifA.BranchAddr, ifA.JumpAddr, ifA.JrAddr); end
        nChecks++; if (ifA.flush_if !== 1'b0 || ifB.flush_if !== 1'b0) begin nFail++; $display("FAIL reset_flush: got %b/%b want 0/0", ifA.flush_if, ifB.flush_if); end
        nChecks++; if (ifA.redirect_cnt !== 16'h0 || ifB.redirect_cnt !== 2'h0) begin nFail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", ifA.redirect_cnt, ifB.redirect_cnt); end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_beq();
        setInstr(1, 1, 0, 0, 0, 32'h0040_0010, 16'h0003, 26'h0, 32'd5, 32'd5);
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b001) begin nFail++; $display("FAIL beq_JRJZ: got %b want 001", ifA.JRJZ); end
        nChecks++; if (ifA.BranchAddr !== 32'h0040_001C) begin nFail++; $display("FAIL beq_addr: got %h want 0040001c", ifA.BranchAddr); end
        nChecks++; if (ifA.flush_if !== 1'b1) begin nFail++; $display("FAIL beq_flushA: got %b want 1", ifA.flush_if); end
        nChecks++; if (ifB.flush_if !== 1'b0) begin nFail++; $display("FAIL beq_flushB: got %b want 0", ifB.flush_if); end
        setInstr(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b000 || ifA.flush_if !== 1'b0) begin nFail++; $display("FAIL beq_release: got %b/%b want 000/0", ifA.JRJZ, ifA.flush_if); end
        nChecks++; if (ifA.redirect_cnt !== 16'd1) begin nFail++; $display("FAIL beq_cnt: got %0d want 1", ifA.redirect_cnt); end
    endtask

    task automatic test_bne();
        setInstr(1, 0, 1, 0, 0, 32'h0000_1000, 16'h0010, 26'h0, 32'd7, 32'd7);
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b000 || ifA.flush_if !== 1'b0) begin nFail++; $display("FAIL bne_nottaken: got %b/%b want 000/0", ifA.JRJZ, ifA.flush_if); end
        cycle();
        nChecks++; if (ifA.redirect_cnt !== 16'd1) begin nFail++; $display("FAIL bne_cnt: got %0d want 1", ifA.redirect_cnt); end
        setInstr(1, 0, 1, 0, 0, 32'h0, 16'hFFFF, 26'h0, 32'd1, 32'd2);
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b001 || ifA.BranchAddr !== 32'hFFFF_FFFC) begin nFail++; $display("FAIL bne_taken: got %b %h want 001 fffffffc", ifA.JRJZ, ifA.BranchAddr); end
        setInstr(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
        cycle();
    endtask

    task automatic test_jump_jr();
        setInstr(1, 0, 0, 1, 0, 32'hA000_0004, 16'h0, 26'h000_0100, 32'h0, 32'h0);
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b010 || ifA.JumpAddr !== 32'hA000_0400) begin nFail++; $display("FAIL j_target: got %b %h want 010 a0000400", ifA.JRJZ, ifA.JumpAddr); end
        nChecks++; if (ifA.BranchAddr !== 32'hFFFF_FFFC) begin nFail++; $display("FAIL j_branch_kept: got %h want fffffffc", ifA.BranchAddr); end
        setInstr(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
        cycle();
        setInstr(1, 0, 0, 0, 1, 32'h0000_0040, 16'h0, 26'h0, 32'h0000_1234, 32'h0);
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b100 || ifA.JrAddr !== 32'h0000_1234) begin nFail++; $display("FAIL jr_target: got %b %h want 100 00001234", ifA.JRJZ, ifA.JrAddr); end
        setInstr(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
        cycle();
    endtask

    task automatic test_stall();
        int cntBefore;
        cntBefore = mCntA;
        setInstr(1, 0, 0, 0, 1, 32'h0000_0080, 16'h0, 26'h0, 32'h0000_5678, 32'h0);
        cycle();
        stall = 1'b1;
        setInstr(1, 0, 0, 0, 1, 32'h0000_0084, 16'h0, 26'h0, 32'hDEAD_BEEF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            nChecks++; if (ifA.JRJZ !== 3'b100 || ifA.JrAddr !== 32'h0000_5678) begin nFail++; $display("FAIL stall_hold%0d: got %b %h want 100 00005678", i, ifA.JRJZ, ifA.JrAddr); end
            nChecks++; if (ifA.redirect_cnt !== 16'(cntBefore)) begin nFail++; $display("FAIL stall_cnt%0d: got %0d want %0d", i, ifA.redirect_cnt, cntBefore); end
        end
        stall = 1'b0;
        setInstr(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
        cycle();
        nChecks++; if (ifA.redirect_cnt !== 16'(cntBefore + 1) || ifA.JRJZ !== 3'b000) begin nFail++; $display("FAIL stall_release: got %0d %b want %0d 000", ifA.redirect_cnt, ifA.JRJZ, cntBefore + 1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] jBefore;
        jBefore = ifA.JumpAddr;
        setInstr(1, 1, 0, 1, 1, 32'h0000_0100, 16'h0004, 26'h0, 32'h0000_0ABC, 32'h0000_0ABC);
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b100 || ifA.JrAddr !== 32'h0000_0ABC) begin nFail++; $display("FAIL prio_jr: got %b %h want 100 00000abc", ifA.JRJZ, ifA.JrAddr); end
        stall = 1'b1;
        setInstr(1, 0, 0, 1, 0, 32'h1000_0000, 16'h0, 26'h000_0002, 32'h0, 32'h0);
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b100 || ifA.JumpAddr !== jBefore) begin nFail++; $display("FAIL b2b_ignored: got %b %h want 100 %h", ifA.JRJZ, ifA.JumpAddr, jBefore); end
        stall = 1'b0;
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b000) begin nFail++; $display("FAIL b2b_consume: got %b want 000", ifA.JRJZ); end
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b010 || ifA.JumpAddr !== 32'h1000_0008) begin nFail++; $display("FAIL b2b_next: got %b %h want 010 10000008", ifA.JRJZ, ifA.JumpAddr); end
        nChecks++; if (ifB.flush_if !== 1'b0) begin nFail++; $display("FAIL b2b_flushB: got %b want 0", ifB.flush_if); end
        setInstr(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            stall = ($urandom_range(0, 9) < 3);
            setInstr(($urandom_range(0, 9) < 7), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), $urandom, 16'($urandom),
                     26'($urandom), a, ($urandom_range(0, 1) == 0) ? a : 32'($urandom));
            cycle();
            nChecks++; if (ifA.JRJZ !== mCode) begin nFail++; $display("FAIL rand_JRJZ cyc %0d: got %b want %b", i, ifA.JRJZ, mCode); end
            nChecks++; if (ifA.BranchAddr !== mBr || ifA.JumpAddr !== mJ || ifA.JrAddr !== mJr) begin nFail++; $display("FAIL rand_addrs cyc %0d: got %h %h %h want %h %h %h", i, ifA.BranchAddr, ifA.JumpAddr, ifA.JrAddr, mBr, mJ, mJr); end
            nChecks++; if (ifA.flush_if !== mPend || ifB.flush_if !== 1'b0) begin nFail++; $display("FAIL rand_flush cyc %0d: got %b/%b want %b/0", i, ifA.flush_if, ifB.flush_if, mPend); end
            nChecks++; if (ifA.redirect_cnt !== 16'(mCntA) || ifB.redirect_cnt !== 2'(mCntB)) begin nFail++; $display("FAIL rand_cnt cyc %0d: got %0d/%0d want %0d/%0d", i, ifA.redirect_cnt, ifB.redirect_cnt, mCntA, mCntB); end
        end
        stall = 1'b0;
        setInstr(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
        cycle();
    endtask

    task automatic test_async_reset();
        nChecks++; if (ifB.redirect_cnt !== 2'd3) begin nFail++; $display("FAIL sat_cntB: got %0d want 3", ifB.redirect_cnt); end
        setInstr(1, 0, 0, 0, 1, 32'h0, 16'h0, 26'h0, 32'h0000_9999, 32'h0);
        cycle();
        stall = 1'b1;
        setInstr(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b100) begin nFail++; $display("FAIL areset_pre: got %b want 100", ifA.JRJZ); end
        #2 reset = 1'b1;
        #1;
        nChecks++; if (ifA.JRJZ !== 3'b000 || ifA.flush_if !== 1'b0) begin nFail++; $display("FAIL areset_JRJZ: got %b/%b want 000/0", ifA.JRJZ, ifA.flush_if); end
        nChecks++; if ({ifA.BranchAddr, ifA.JumpAddr, ifA.JrAddr} !== 96'h0) begin nFail++; $display("FAIL areset_addrs: got %h %h %h want 0", ifA.BranchAddr, ifA.JumpAddr, ifA.JrAddr); end
        nChecks++; if (ifA.redirect_cnt !== 16'h0 || ifB.redirect_cnt !== 2'h0) begin nFail++; $display("FAIL areset_cnt: got %0d/%0d want 0/0", ifA.redirect_cnt, ifB.redirect_cnt); end
        #1 reset = 1'b0;
        stall = 1'b0;
        modelReset();
        cycle();
        nChecks++; if (ifA.JRJZ !== 3'b000) begin nFail++; $display("FAIL areset_idle: got %b want 000", ifA.JRJZ); end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_bne();
        test_jump_jr();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, limit 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
